// File: rtl/vec_pkg.sv
// vec_pkg: shared widths, opcode encodings and sequencer state type used by
// the vector ALU sequencer and its neighbours (register file, ALU).
package vec_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int VLEN   = LANES * LANE_W;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    LAT2,
    EXEC,
    WB_LO,
    WB_HI
  } seq_state_t;

endpackage

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: runs one vector ALU instruction at a time.
// It reads two source vectors from a single-port register file (1-cycle read),
// feeds them to the ALU, captures the 64-bit lane results, and writes the low
// words to dst and, for wide commands, the high words to dst+1 (wrapping).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_wide         0=add 1=mul, write high words too
//   cmd_src1/src2/dst        register indices
//   rf_raddr, rf_rdata       register file read port (data one cycle later)
//   rf_we/waddr/wdata        register file write port
//   alu_op, alu_in1/in2      ALU operands (always driven from registers)
//   alu_out1/out2            ALU low/high 32 bits per lane
//   busy, done               not-IDLE flag, final write-back pulse
//
// State | meaning
// IDLE  | waiting for a command, cmd_ready high
// RD1   | address src1 on the read port
// RD2   | address src2, capture src1 data
// LAT2  | capture src2 data
// EXEC  | operands on the ALU, capture results
// WB_LO | write low words to dst
// WB_HI | write high words to dst+1 (wide only)
module vec_alu_sequencer
  import vec_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_wide,
  input  logic [REG_AW-1:0] cmd_src1,
  input  logic [REG_AW-1:0] cmd_src2,
  input  logic [REG_AW-1:0] cmd_dst,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [VLEN-1:0]   rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [VLEN-1:0]   rf_wdata,
  output logic              alu_op,
  output logic [VLEN-1:0]   alu_in1,
  output logic [VLEN-1:0]   alu_in2,
  input  logic [VLEN-1:0]   alu_out1,
  input  logic [VLEN-1:0]   alu_out2,
  output logic              busy,
  output logic              done
);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic              r_op;
  logic              r_wide;
  logic [REG_AW-1:0] r_src1;
  logic [REG_AW-1:0] r_src2;
  logic [REG_AW-1:0] r_dst;
  logic [VLEN-1:0]   r_op1;
  logic [VLEN-1:0]   r_op2;
  logic [VLEN-1:0]   r_res_lo;
  logic [VLEN-1:0]   r_res_hi;
  logic [REG_AW-1:0] w_dst_hi;

  // High-word destination wraps around the register file.
  assign w_dst_hi = REG_AW'((32'(r_dst) + 1) % NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= 1'b0;
      r_wide   <= 1'b0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_dst    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_wide <= cmd_wide;
            r_src1 <= cmd_src1;
            r_src2 <= cmd_src2;
            r_dst  <= cmd_dst;
          end
        end
        RD2:  r_op1 <= rf_rdata;
        LAT2: r_op2 <= rf_rdata;
        EXEC: begin
          r_res_lo <= alu_out1;
          r_res_hi <= alu_out2;
        end
        default: ;
      endcase
    end
  end

  assign alu_op  = r_op;
  assign alu_in1 = r_op1;
  assign alu_in2 = r_op2;

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    rf_raddr     = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next_state = RD1;
      end
      RD1: begin
        rf_raddr     = r_src1;
        w_next_state = RD2;
      end
      RD2: begin
        rf_raddr     = r_src2;
        w_next_state = LAT2;
      end
      LAT2: w_next_state = EXEC;
      EXEC: w_next_state = WB_LO;
      WB_LO: begin
        rf_we    = 1'b1;
        rf_waddr = r_dst;
        rf_wdata = r_res_lo;
        if (r_wide) begin
          w_next_state = WB_HI;
        end else begin
          done         = 1'b1;
          w_next_state = IDLE;
        end
      end
      WB_HI: begin
        rf_we        = 1'b1;
        rf_waddr     = w_dst_hi;
        rf_wdata     = r_res_hi;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
module tb_vec_alu_sequencer;
  import vec_pkg::*;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic            cmd_wide;
  logic [1:0]      cmd_src1;
  logic [1:0]      cmd_src2;
  logic [1:0]      cmd_dst;
  logic [1:0]      rf_raddr;
  logic [VLEN-1:0] rf_rdata;
  logic            rf_we;
  logic [1:0]      rf_waddr;
  logic [VLEN-1:0] rf_wdata;
  logic            alu_op;
  logic [VLEN-1:0] alu_in1;
  logic [VLEN-1:0] alu_in2;
  logic [VLEN-1:0] alu_out1;
  logic [VLEN-1:0] alu_out2;
  logic            busy;
  logic            done;

  vec_alu_sequencer #(.NUM_REGS(4), .REG_AW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wide(cmd_wide),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out1(alu_out1), .alu_out2(alu_out2),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference lane-wise signed ALU: hi selects the upper 32 bits of the 64-bit result.
  function automatic logic [VLEN-1:0] alu_f(logic op, logic [VLEN-1:0] a, logic [VLEN-1:0] b,
                                            logic hi);
    logic [VLEN-1:0]    r;
    logic signed [31:0] x, y;
    logic signed [63:0] xe, ye, p;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      x  = a[l*LANE_W +: LANE_W];
      y  = b[l*LANE_W +: LANE_W];
      xe = x;
      ye = y;
      p  = op ? xe * ye : xe + ye;
      r[l*LANE_W +: LANE_W] = hi ? p[63:32] : p[31:0];
    end
    return r;
  endfunction

  always_comb begin
    alu_out1 = alu_f(alu_op, alu_in1, alu_in2, 1'b0);
    alu_out2 = alu_f(alu_op, alu_in1, alu_in2, 1'b1);
  end

  // Behavioural register file with 1-cycle read.
  logic [VLEN-1:0] mem [4];
  always @(posedge clk) begin
    rf_rdata <= mem[rf_raddr];
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  function automatic logic [VLEN-1:0] fill(logic [31:0] l0, logic [31:0] rest);
    logic [VLEN-1:0] r;
    r = {LANES{rest}};
    r[31:0] = l0;
    return r;
  endfunction

  typedef struct {
    logic [1:0]      addr;
    logic [VLEN-1:0] data;
    int              cyc;
    logic            last;
  } wr_t;
  wr_t q[$];

  typedef struct {
    logic        op;
    logic        wide;
    logic [1:0]  s1, s2, d;
    logic [31:0] a0, a, b0, b, lo0, lo, hi0, hi;
  } vec_t;
  vec_t tv[6];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [VLEN-1:0] act, logic [VLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    if (rf_we) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got write to r%0d at cycle %0d, required none", rf_waddr, cyc);
      end else begin
        e = q.pop_front();
        chk("wr_addr", VLEN'(rf_waddr), VLEN'(e.addr));
        chk("wr_data", rf_wdata, e.data);
        chki("wr_cycle", cyc, e.cyc);
        chki("wr_done", int'(done), int'(e.last));
      end
    end else if (done) begin
      n_chk++;
      n_err++;
      $display("FAIL done_without_write: got done=1 at cycle %0d, required 0", cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  // Offers a command and waits (bounded) for acceptance. acc is the cycle number
  // observed just before the accept edge; writes are due at acc+5 and acc+6.
  task automatic issue(logic op, logic wide, logic [1:0] s1, logic [1:0] s2, logic [1:0] d,
                       logic push, logic [VLEN-1:0] lo, logic [VLEN-1:0] hi, output int acc);
    logic       got;
    logic [1:0] dh;
    wr_t        e;
    got       = 1'b0;
    acc       = -1;
    dh        = d + 2'd1;
    cmd_op    = op;
    cmd_wide  = wide;
    cmd_src1  = s1;
    cmd_src2  = s2;
    cmd_dst   = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cmd_ready && !rst) begin
        got = 1'b1;
        acc = cyc;
        if (push) begin
          e.addr = d;  e.data = lo; e.cyc = acc + 5; e.last = !wide;
          q.push_back(e);
          if (wide) begin
            e.addr = dh; e.data = hi; e.cyc = acc + 6; e.last = 1'b1;
            q.push_back(e);
          end
        end
      end
      tick();
    end
    if (!got) chki("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0 && !busy) break;
      tick();
    end
    chki("drain", q.size(), 0);
    q.delete();
  endtask

  int acc, acc_a, acc_b;
  logic [VLEN-1:0] va, vb;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_wide = 1'b0;
    cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;

    tv[0] = '{OP_ADD, 1'b1, 2'd0, 2'd1, 2'd2, 32'h7FFFFFFF, 32'h00000010, 32'h00000001,
              32'hFFFFFFF0, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000};
    tv[1] = '{OP_ADD, 1'b1, 2'd0, 2'd1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tv[2] = '{OP_MUL, 1'b1, 2'd0, 2'd1, 2'd3, 32'h00010000, 32'hFFFFFFFE, 32'h00010000,
              32'h00000003, 32'h00000000, 32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFF};
    tv[3] = '{OP_MUL, 1'b0, 2'd1, 2'd1, 2'd1, 32'h00000005, 32'h00000005, 32'h00000005,
              32'h00000005, 32'h00000019, 32'h00000019, 32'h00000000, 32'h00000000};
    tv[4] = '{OP_MUL, 1'b1, 2'd2, 2'd3, 2'd0, 32'h80000000, 32'hFFFFFFFD, 32'h80000000,
              32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 32'h40000000, 32'h00000000};
    tv[5] = '{OP_ADD, 1'b0, 2'd3, 2'd0, 2'd3, 32'h00000001, 32'h80000000, 32'h00000002,
              32'h80000000, 32'h00000003, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};

    repeat (3) tick();
    chki("rst_cmd_ready", int'(cmd_ready), 1);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_rf_we", int'(rf_we), 0);
    chki("rst_rf_waddr", int'(rf_waddr), 0);
    chki("rst_rf_raddr", int'(rf_raddr), 0);
    chki("rst_alu_op", int'(alu_op), 0);
    chk("rst_rf_wdata", rf_wdata, '0);
    chk("rst_alu_in1", alu_in1, '0);
    chk("rst_alu_in2", alu_in2, '0);
    rst = 1'b0;
    tick();

    // Table-driven vectors.
    for (int v = 0; v < 6; v++) begin
      mem[tv[v].s1] = fill(tv[v].a0, tv[v].a);
      mem[tv[v].s2] = fill(tv[v].b0, tv[v].b);
      issue(tv[v].op, tv[v].wide, tv[v].s1, tv[v].s2, tv[v].d, 1'b1,
            fill(tv[v].lo0, tv[v].lo), fill(tv[v].hi0, tv[v].hi), acc);
      cmd_valid = 1'b0;
      wait_idle();
    end

    // Back-to-back held command: second accepted the cycle after the first done.
    va = fill(32'd7, 32'd7);
    vb = fill(32'd9, 32'd9);
    mem[0] = va;
    mem[1] = vb;
    issue(OP_ADD, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, alu_f(OP_ADD, va, vb, 1'b0), '0, acc_a);
    issue(OP_MUL, 1'b0, 2'd0, 2'd1, 2'd3, 1'b1, alu_f(OP_MUL, va, vb, 1'b0), '0, acc_b);
    cmd_valid = 1'b0;
    chki("b2b_accept_cycle", acc_b, acc_a + 6);
    wait_idle();

    // A command pulsed while busy is dropped.
    issue(OP_ADD, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1, alu_f(OP_ADD, vb, vb, 1'b0), '0, acc);
    cmd_valid = 1'b0;
    tick();
    cmd_op = OP_MUL; cmd_wide = 1'b1; cmd_dst = 2'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle();
    repeat (8) tick();
    chki("drop_idle_busy", int'(busy), 0);

    // Reset during EXEC aborts the instruction.
    mem[2] = fill(32'd11, 32'd11);
    issue(OP_ADD, 1'b1, 2'd2, 2'd2, 2'd1, 1'b0, '0, '0, acc);
    cmd_valid = 1'b0;
    while (cyc < acc + 4) tick();
    chki("exec_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chki("abort_cmd_ready", int'(cmd_ready), 1);
    chki("abort_busy", int'(busy), 0);
    repeat (8) tick();
    chki("abort_rf_kept", int'(mem[1][31:0]), 9);

    // Reset has priority over a simultaneous command.
    rst = 1'b1;
    cmd_valid = 1'b1;
    tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();
    chki("rst_prio_busy", int'(busy), 0);

    // Fresh command completes after the abort.
    va = fill(32'h00000002, 32'hFFFFFFFF);
    mem[2] = va;
    mem[3] = va;
    issue(OP_MUL, 1'b1, 2'd2, 2'd3, 2'd3, 1'b1, alu_f(OP_MUL, va, va, 1'b0),
          alu_f(OP_MUL, va, va, 1'b1), acc);
    cmd_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
